// File: rtl/hit_sound_gen.sv
// hit_sound_gen: turns brick/wall and paddle hit requests into square-wave tone bursts
module hit_sound_gen #(
    parameter int CNT_W      = 24,
    parameter int TONE1_HALF = 25000,
    parameter int TONE2_HALF = 50000,
    parameter int DUR1       = 2500000,
    parameter int DUR2       = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play_sound1,
    input  logic       play_sound2,
    input  logic       mute,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] tone_id
);
    typedef enum logic [1:0] {IDLE = 2'd0, TONE1 = 2'd1, TONE2 = 2'd2} state_t;
    state_t           state_q;
    logic [1:0]       s1_q, s2_q, p_q, req;
    logic [CNT_W-1:0] dur_q, half_q, half_lim;
    logic             phase_q, phase_d, wrap, busy_q, speaker_q;
    // bit 1 is the paddle request, bit 0 the brick/wall request
    assign req      = s2_q & ~p_q;
    assign half_lim = state_q == TONE2 ? CNT_W'(TONE2_HALF - 1) : CNT_W'(TONE1_HALF - 1);
    assign wrap     = half_q == half_lim;
    assign phase_d  = phase_q ^ wrap;
    assign speaker  = speaker_q;
    assign busy     = busy_q;
    assign tone_id  = state_q;
    // synchronisers, edge detect, burst FSM and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            p_q       <= '0;
            state_q   <= IDLE;
            dur_q     <= '0;
            half_q    <= '0;
            phase_q   <= 1'b0;
            busy_q    <= 1'b0;
            speaker_q <= 1'b0;
        end else begin
            s1_q <= {play_sound2, play_sound1};
            s2_q <= s1_q;
            p_q  <= s2_q;
            if (req[1] || (req[0] && state_q != TONE2)) begin
                state_q   <= req[1] ? TONE2 : TONE1;
                dur_q     <= req[1] ? CNT_W'(DUR2 - 1) : CNT_W'(DUR1 - 1);
                half_q    <= '0;
                phase_q   <= 1'b0;
                busy_q    <= 1'b1;
                speaker_q <= 1'b0;
            end else if (state_q != IDLE) begin
                if (dur_q == '0) begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    speaker_q <= 1'b0;
                end else begin
                    dur_q     <= dur_q - 1'b1;
                    half_q    <= wrap ? '0 : half_q + 1'b1;
                    phase_q   <= phase_d;
                    speaker_q <= phase_d & ~mute;
                end
            end
        end
    end
endmodule

// File: tb/tb_hit_sound_gen.sv
// tb_hit_sound_gen: directed and random stimulus checked against a burst-timing model
module tb_hit_sound_gen;
    localparam int H1 = 4, H2 = 8, D1 = 40, D2 = 64;
    logic       clk = 1'b0, reset = 1'b1, ps1 = 1'b0, ps2 = 1'b0, mute = 1'b0;
    logic       speaker, busy;
    logic [1:0] tone_id;
    int         n_chk = 0, n_pass = 0;
    logic [1:0] hist[$];
    int         m_tone = 0, m_start = 0;

    hit_sound_gen #(.CNT_W(8), .TONE1_HALF(H1), .TONE2_HALF(H2), .DUR1(D1), .DUR2(D2)) dut (
        .clk(clk), .reset(reset), .play_sound1(ps1), .play_sound2(ps2), .mute(mute),
        .speaker(speaker), .busy(busy), .tone_id(tone_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // one clock: drive at negedge, advance model at posedge, compare 1 time unit later
    task automatic step(input logic a, input logic b, input logic m, input logic r);
        logic [1:0] cur, req, old2, old3;
        int k, h, e;
        @(negedge clk);
        ps1 = a; ps2 = b; mute = m; reset = r;
        @(posedge clk);
        cur = r ? 2'b00 : {b, a};
        if (r) hist = {};
        hist.push_back(cur);
        k    = hist.size() - 1;
        old2 = k >= 2 ? hist[k-2] : 2'b00;
        old3 = k >= 3 ? hist[k-3] : 2'b00;
        req  = old2 & ~old3;
        if (r) m_tone = 0;
        else if (req[1]) begin m_tone = 2; m_start = k; end
        else if (req[0] && m_tone != 2) begin m_tone = 1; m_start = k; end
        else if (m_tone != 0 && k - m_start >= (m_tone == 2 ? D2 : D1)) m_tone = 0;
        h = m_tone == 2 ? H2 : H1;
        e = (m_tone != 0 && !m && ((k - m_start) / h) % 2 == 1) ? 1 : 0;
        #1;
        chk("busy", busy, m_tone != 0);
        chk("tone_id", tone_id, m_tone);
        chk("speaker", speaker, e);
    endtask

    initial begin
        int cnt, rise;
        logic a, b, m, r;
        repeat (3) step(0, 0, 0, 1);
        chk("rst_speaker", speaker, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tone", tone_id, 0);
        // single tone 1 burst: measure its length and first rise
        step(1, 0, 0, 0);
        cnt = 0; rise = -1;
        for (int i = 0; i < 60; i++) begin
            step(0, 0, 0, 0);
            if (busy) cnt++;
            if (busy && speaker && rise < 0) rise = cnt;
        end
        chk("t1_len", cnt, D1);
        chk("t1_first_rise", rise, H1 + 1);
        // held paddle request: one burst only
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step(0, 1, 0, 0);
            if (busy) cnt++;
        end
        chk("t2_len", cnt, D2);
        repeat (5) step(0, 0, 0, 0);
        // simultaneous rise: paddle wins, brick request not queued
        repeat (2) step(1, 1, 0, 0);
        repeat (90) step(0, 0, 0, 0);
        // pre-empt tone 1 by tone 2, 10 cycles in
        step(1, 0, 0, 0);
        repeat (11) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (80) step(0, 0, 0, 0);
        // brick request during tone 2 is ignored
        step(0, 1, 0, 0);
        repeat (20) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (60) step(0, 0, 0, 0);
        // muted tone 1
        step(1, 0, 1, 0);
        repeat (50) step(0, 0, 1, 0);
        // reset mid-burst
        step(1, 0, 0, 0);
        repeat (22) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("mid_rst_busy", busy, 0);
        repeat (10) step(0, 0, 0, 0);
        // random traffic
        a = 0; b = 0; m = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 19) == 0) a = ~a;
            if ($urandom_range(0, 39) == 0) b = ~b;
            if ($urandom_range(0, 49) == 0) m = ~m;
            r = $urandom_range(0, 299) == 0;
            step(a, b, m, r);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
